// File: rtl/opamp_cmp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : opamp_cmp_sequencer
//  Description : Powers an open-loop opamp comparator, waits for it to settle,
//                majority-votes NSAMP synchronised samples and optionally
//                chops the inputs to cancel offset.
//  Revision    : 1.0 - initial release
// ============================================================================
module opamp_cmp_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int NSAMP         = 8,
    parameter int CNT_W         = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             chop_en_i,
    input  logic             abort_i,
    input  logic             cmp_i,
    output logic             opamp_en_o,
    output logic             swap_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic             result_o,
    output logic [CNT_W-1:0] ones_cnt_o,
    output logic             err_o
);

    localparam int TMAX = (SETTLE_CYCLES > NSAMP) ? SETTLE_CYCLES : NSAMP;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]  c_SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]  c_SAMP_LAST   = TW'(NSAMP - 1);
    localparam logic [CNT_W:0] c_NSAMP       = (CNT_W + 1)'(NSAMP);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SETTLE      = 3'd1,
        S_SAMPLE_A    = 3'd2,
        S_SWAP_SETTLE = 3'd3,
        S_SAMPLE_B    = 3'd4,
        S_DONE        = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TW-1:0]     r_tmr;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_chop;
    logic [CNT_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnta;
    logic [CNT_W-1:0]  r_cntb;
    logic [CNT_W-1:0]  w_acc_nxt;
    logic [CNT_W-1:0]  w_cnta_nxt;
    logic [CNT_W-1:0]  w_cntb_nxt;
    logic [CNT_W-1:0]  w_samp;
    logic [CNT_W-1:0]  w_samp_inv;
    logic              w_load;
    logic              w_res;
    logic              w_err;
    logic              r_result;
    logic [CNT_W-1:0]  r_ones;
    logic              r_err;

    // Two-flop synchroniser for the asynchronous comparator output
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= cmp_i;
            r_sync2 <= r_sync1;
        end
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i && !abort_i) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_tmr == c_SETTLE_LAST) w_state_nxt = S_SAMPLE_A;
            end
            S_SAMPLE_A: begin
                if (r_tmr == c_SAMP_LAST) w_state_nxt = r_chop ? S_SWAP_SETTLE : S_DONE;
            end
            S_SWAP_SETTLE: begin
                if (r_tmr == c_SETTLE_LAST) w_state_nxt = S_SAMPLE_B;
            end
            S_SAMPLE_B: begin
                if (r_tmr == c_SAMP_LAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = cont_i ? S_SETTLE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort_i && r_state != S_IDLE) w_state_nxt = S_IDLE;
    end

    // Per-state cycle timer, restarted on every state change
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || (w_state_nxt != r_state) || (r_state == S_IDLE)) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    // Chop mode is captured whenever a conversion (re)starts
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_chop <= 1'b0;
        end else if (w_state_nxt == S_SETTLE && r_state != S_SETTLE) begin
            r_chop <= chop_en_i;
        end
    end

    assign w_samp     = {{(CNT_W-1){1'b0}}, r_sync2};
    assign w_samp_inv = {{(CNT_W-1){1'b0}}, ~r_sync2};

    // Accumulator update: cleared while settling, phase B counts the inverted sample
    always_comb begin
        w_acc_nxt  = r_acc;
        w_cnta_nxt = r_cnta;
        w_cntb_nxt = r_cntb;
        case (r_state)
            S_SETTLE: begin
                w_acc_nxt  = '0;
                w_cnta_nxt = '0;
                w_cntb_nxt = '0;
            end
            S_SAMPLE_A: begin
                w_acc_nxt  = r_acc + w_samp;
                w_cnta_nxt = r_cnta + w_samp;
            end
            S_SAMPLE_B: begin
                w_acc_nxt  = r_acc + w_samp_inv;
                w_cntb_nxt = r_cntb + w_samp;
            end
            default: ;
        endcase
    end

    // Accumulator registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_acc  <= '0;
            r_cnta <= '0;
            r_cntb <= '0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_cnta <= w_cnta_nxt;
            r_cntb <= w_cntb_nxt;
        end
    end

    // Results are loaded on entry to DONE so they line up with valid_o
    assign w_load = (w_state_nxt == S_DONE) && (r_state != S_DONE);
    assign w_res  = r_chop ? ({1'b0, w_acc_nxt} > c_NSAMP)
                           : ({w_acc_nxt, 1'b0} > c_NSAMP);
    assign w_err  = r_chop && (({w_cnta_nxt, 1'b0} > c_NSAMP) ==
                               ({w_cntb_nxt, 1'b0} > c_NSAMP));

    // Result registers hold until the next completed conversion
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_result <= 1'b0;
            r_ones   <= '0;
            r_err    <= 1'b0;
        end else if (w_load) begin
            r_result <= w_res;
            r_ones   <= w_acc_nxt;
            r_err    <= w_err;
        end
    end

    assign opamp_en_o = (r_state != S_IDLE);
    assign busy_o     = (r_state != S_IDLE);
    assign swap_o     = (r_state == S_SWAP_SETTLE) || (r_state == S_SAMPLE_B);
    assign valid_o    = (r_state == S_DONE);
    assign result_o   = r_result;
    assign ones_cnt_o = r_ones;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_opamp_cmp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opamp_cmp_sequencer
//  Description : Scoreboard bench for opamp_cmp_sequencer. Stimulus builds a
//                comparator waveform per sequence, derives expected results
//                from the sampling rules and queues them; a monitor checks
//                each valid_o pulse against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_opamp_cmp_sequencer;

    localparam int SC    = 4;
    localparam int NS    = 8;
    localparam int CW    = 8;
    localparam int LAT_N = SC + NS + 1;
    localparam int LAT_C = 2*SC + 2*NS + 1;

    localparam int M_RAND  = 0;
    localparam int M_ONE   = 1;
    localparam int M_IDEAL = 2;
    localparam int M_TIE   = 3;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          cont  = 1'b0;
    logic          chop  = 1'b0;
    logic          abort = 1'b0;
    logic          cmp   = 1'b0;
    logic          opamp_en;
    logic          swap;
    logic          busy;
    logic          valid;
    logic          result;
    logic [CW-1:0] ones;
    logic          err;

    opamp_cmp_sequencer #(
        .SETTLE_CYCLES (SC),
        .NSAMP         (NS),
        .CNT_W         (CW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start_i    (start),
        .cont_i     (cont),
        .chop_en_i  (chop),
        .abort_i    (abort),
        .cmp_i      (cmp),
        .opamp_en_o (opamp_en),
        .swap_o     (swap),
        .busy_o     (busy),
        .valid_o    (valid),
        .result_o   (result),
        .ones_cnt_o (ones),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit res;
        int ones;
        bit err;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   exp_res  = 1'b0;
    int   exp_ones = 0;
    bit   exp_err  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid_o pulse must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("result", result, e.res);
                chk("ones_cnt", ones, e.ones);
                chk("err", err, e.err);
            end
        end
    end

    // One or more back-to-back conversions; optional abort or reset at a relative cycle
    task automatic run_seq(input int n, input bit ch, input int mode,
                           input int abort_at, input int rst_at, input bit noise);
        int lat, len, stop, t0, a, b, cnt, r;
        bit res, er, on, sw;
        bit wave[];
        lat  = ch ? LAT_C : LAT_N;
        len  = n*lat + 1;
        wave = new[len];
        t0   = cyc;
        for (int j = 0; j < len; j++) begin
            case (mode)
                M_RAND:  wave[j] = 1'($urandom_range(0, 1));
                M_ONE:   wave[j] = 1'b1;
                M_IDEAL: begin
                    r = (j == 0) ? 0 : ((j - 1) % lat) + 1;
                    wave[j] = !(r >= SC + NS + 1 && r <= 2*SC + 2*NS);
                end
                default: wave[j] = 1'b0;
            endcase
        end
        if (mode == M_TIE)
            for (int i = 0; i < n; i++)
                for (int k = 0; k < NS; k++) wave[i*lat + SC - 1 + k] = (k < NS/2);
        stop = n*lat;
        if (abort_at >= 0) stop = abort_at;
        if (rst_at >= 0)   stop = rst_at;

        // Model: sample in cycle c sees cmp from cycle c-2
        for (int i = 0; i < n; i++) begin
            if ((abort_at < 0 && rst_at < 0) || (abort_at >= 0 && (i+1)*lat <= stop) ||
                (rst_at >= 0 && (i+1)*lat < stop)) begin
                a = 0;
                b = 0;
                for (int k = 0; k < NS; k++) a += int'(wave[i*lat + SC - 1 + k]);
                if (ch) for (int k = 0; k < NS; k++) b += int'(wave[i*lat + 2*SC + NS - 1 + k]);
                cnt = ch ? a + (NS - b) : a;
                res = ch ? (cnt > NS) : (2*cnt > NS);
                er  = ch ? ((2*a > NS) == (2*b > NS)) : 1'b0;
                sbq.push_back('{t0 + (i+1)*lat, res, cnt, er});
                exp_res  = res;
                exp_ones = cnt;
                exp_err  = er;
            end
        end

        for (int j = 0; j <= stop; j++) begin
            start = (j == 0) || (noise && j < n*lat && $urandom_range(0, 3) == 0);
            cont  = (j < (n-1)*lat + 4);
            chop  = ch;
            abort = (j == abort_at);
            rst   = (j == rst_at);
            cmp   = wave[j];
            on = (j >= 1 && j <= n*lat);
            r  = (j == 0) ? 0 : ((j - 1) % lat) + 1;
            sw = ch && on && (r >= SC + NS + 1) && (r <= 2*SC + 2*NS);
            chk("opamp_en", opamp_en, on);
            chk("busy", busy, on);
            chk("swap", swap, sw);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        cont  = 1'b0;
        if (rst_at >= 0) begin
            exp_res  = 1'b0;
            exp_ones = 0;
            exp_err  = 1'b0;
        end
        chk("idle_busy", busy, 1'b0);
        chk("idle_opamp_en", opamp_en, 1'b0);
        chk("idle_swap", swap, 1'b0);
        chk("hold_result", result, exp_res);
        chk("hold_ones", ones, exp_ones);
        chk("hold_err", err, exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, ab;
        bit ch;
        // Reset with a toggling comparator input
        rst = 1'b1;
        repeat (2) begin
            cmp = ~cmp;
            tick();
        end
        chk("rst_opamp_en", opamp_en, 1'b0);
        chk("rst_swap", swap, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_result", result, 1'b0);
        chk("rst_ones", ones, 0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        repeat (4) begin
            cmp = ~cmp;
            tick();
            chk("idle_after_rst", busy, 1'b0);
        end

        run_seq(1, 1'b0, M_ONE,   -1, -1, 1'b0);   // single shot, all ones
        run_seq(1, 1'b0, M_TIE,   -1, -1, 1'b0);   // tie resolves to 0
        run_seq(1, 1'b1, M_IDEAL, -1, -1, 1'b0);   // chopped, ideal comparator
        run_seq(1, 1'b1, M_ONE,   -1, -1, 1'b0);   // chopped, offset-dominated
        run_seq(1, 1'b0, M_ONE,    8, -1, 1'b0);   // abort mid-conversion
        run_seq(1, 1'b0, M_ONE,   -1, -1, 1'b0);   // clean restart after abort
        run_seq(3, 1'b0, M_ONE,   -1, -1, 1'b0);   // continuous mode
        run_seq(3, 1'b0, M_RAND,  -1, 20, 1'b0);   // reset during continuous mode
        run_seq(2, 1'b1, M_RAND,  -1, -1, 1'b1);   // continuous chopped, start noise

        for (int t = 0; t < 14; t++) begin
            n  = $urandom_range(1, 3);
            ch = 1'($urandom_range(0, 1));
            m  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : M_RAND;
            ab = ($urandom_range(0, 3) == 0)
                 ? int'($urandom_range(0, n * (ch ? LAT_C : LAT_N))) : -1;
            run_seq(n, ch, m, ab, -1, 1'b1);
        end

        repeat (3) tick();
        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
